// File: rtl/fetch_unit.sv
// fetch_unit: PC register plus IF/ID pipeline register for the RV32 core.
// Optional perf counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;
  logic        advance;
  logic        stall_hold;
  logic [1:0]  unused_tgt_lsb;

  assign imem_addr   = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign redirect_pc = {redirect_target[31:2], 2'b00};
  assign advance     = !redirect_valid && !stall;
  assign stall_hold  = !redirect_valid && stall;

  // Target is word aligned; the low bits are dropped on purpose.
  assign unused_tgt_lsb = redirect_target[1:0];

  // Program counter: reset, then redirect, then stall, else +4.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc;
    end else if (!stall) begin
      pc_q <= pc_plus4;
    end
  end

  // IF/ID register: flush to a NOP on redirect, hold on stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_id_valid    <= 1'b0;
      if_id_instr    <= NOP_INSTR;
      if_id_pc       <= 32'd0;
      if_id_pc_plus4 <= 32'd0;
    end else if (redirect_valid) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end else if (advance) begin
      if_id_valid    <= 1'b1;
      if_id_instr    <= imem_rdata;
      if_id_pc       <= pc_q;
      if_id_pc_plus4 <= pc_plus4;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Perf counters: fetched instructions and stalled cycles, wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (advance) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (stall_hold) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`else
  logic unused_stall_hold;
  assign unused_stall_hold = stall_hold;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus random checks of fetch_unit
// against a cycle-level behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic [31:0] if_id_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  logic [31:0] rom [256];

  int compared = 0;
  int mismatched = 0;

  // model state
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_ipc;
  logic [31:0] m_ipc4;
  logic [31:0] m_instr;
  logic [31:0] m_fetch;
  logic [31:0] m_stall;
  logic [31:0] stall_base;

  fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .if_id_valid     (if_id_valid),
    .if_id_pc        (if_id_pc),
    .if_id_pc_plus4  (if_id_pc_plus4),
    .if_id_instr     (if_id_instr)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_stall_cnt  (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign imem_rdata = rom[imem_addr[9:2]];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("imem_addr", imem_addr, m_pc);
    check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    check("if_id_pc", if_id_pc, m_ipc);
    check("if_id_pc_plus4", if_id_pc_plus4, m_ipc4);
    check("if_id_instr", if_id_instr, m_instr);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch_cnt", perf_fetch_cnt, m_fetch);
    check("perf_stall_cnt", perf_stall_cnt, m_stall);
`endif
  endtask

  // One clock edge: drive, update model by the priority rules, check.
  task automatic step(input logic r, input logic s, input logic rv,
                      input logic [31:0] tgt);
    rst_n = r;
    stall = s;
    redirect_valid = rv;
    redirect_target = tgt;
    @(posedge clk);
    if (!r) begin
      m_pc = 32'h0; m_valid = 0; m_instr = NOP;
      m_ipc = 0; m_ipc4 = 0; m_fetch = 0; m_stall = 0;
    end else if (rv) begin
      m_pc = tgt & ~32'd3; m_valid = 0; m_instr = NOP;
    end else if (s) begin
      m_stall = m_stall + 1;
    end else begin
      m_instr = rom[m_pc[9:2]];
      m_ipc = m_pc;
      m_ipc4 = m_pc + 4;
      m_pc = m_pc + 4;
      m_valid = 1;
      m_fetch = m_fetch + 1;
    end
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[0] = 32'h0010_0093;
    rom[1] = 32'h0020_0113;
    rom[2] = 32'h0020_81B3;

    // reset state
    step(0, 0, 0, 0);
    step(0, 1, 1, 32'h80);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_instr", if_id_instr, NOP);

    // straight-line fetch and stall at pc 8
    step(1, 0, 0, 0);
    check("sl0_instr", if_id_instr, 32'h0010_0093);
    check("sl0_pc4", if_id_pc_plus4, 32'h4);
    step(1, 0, 0, 0);
    check("sl1_instr", if_id_instr, 32'h0020_0113);
    stall_base = m_stall;
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    check("stall_addr", imem_addr, 32'h8);
    check("stall_pc", if_id_pc, 32'h4);
    check("stall_cnt", m_stall - stall_base, 32'd2);
    step(1, 0, 0, 0);
    check("sl2_instr", if_id_instr, 32'h0020_81B3);
    check("sl2_pc4", if_id_pc_plus4, 32'hC);

    // redirect at pc 0xC
    step(1, 0, 1, 32'h40);
    check("rd_addr", imem_addr, 32'h40);
    check("rd_instr", if_id_instr, NOP);
    step(1, 0, 0, 0);
    check("rd_pc", if_id_pc, 32'h40);

    // redirect together with stall, unaligned target
    step(1, 1, 1, 32'h103);
    check("rds_addr", imem_addr, 32'h100);

    // redirect to the current pc still flushes
    step(1, 0, 0, 0);
    step(1, 0, 1, 32'h104);
    check("self_valid", {31'd0, if_id_valid}, 32'd0);

    // wrap at top of address space
    step(1, 0, 1, 32'hFFFF_FFFC);
    step(1, 0, 0, 0);
    check("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", if_id_pc_plus4, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);

    // reset during stall at pc 0x20
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
    check("pre_rst_addr", imem_addr, 32'h20);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    check("mid_rst_addr", imem_addr, 32'h0);
    check("mid_rst_valid", {31'd0, if_id_valid}, 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic r, s, rv;
      logic [31:0] t;
      r  = ($urandom_range(0, 49) != 0);
      s  = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 5) == 0);
      t  = $urandom;
      if ($urandom_range(0, 1) == 1) t = {22'd0, t[9:0]};
      step(r, s, rv, t);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
